// File: rtl/hs_fifo_sfifo_pkt.sv
// rtl/hs_fifo_sfifo_pkt.sv - single-clock packet FIFO with store-and-forward, drop and oversize discard
// Reader only sees entries below cm_ptr; rd_ptr frees memory when a beat leaves the output register.
module hs_fifo_sfifo_pkt #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int PKT_MODE   = 1,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2,
  localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wlast,
  input  logic                  wdrop,
  output logic                  walmost_full,
  output logic [LW-1:0]         wlevel,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rlast,
  output logic                  ralmost_empty,
  output logic [LW-1:0]         rlevel,
  output logic                  drop_pulse
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] FULL_X  = {1'b1, {AW{1'b0}}};
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_DISCARD
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr, fe_ptr;
  logic [PW-1:0] wr_nx, cm_nx, rd_nx, fe_nx;
  logic [PW-1:0] wr_inc;
  logic [PW-1:0] wlevel_nx, rlevel_nx;
  logic          full_nx;
  logic          overflow;
  logic          wfire, pop, load, wr_en, drop_nx;

  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic                  wready_q, out_valid, out_last, drop_q, af_q, ae_q;
  logic [DATA_WIDTH-1:0] out_data;

  always_comb begin
    wfire    = wvalid && wready_q;
    pop      = out_valid && rready;
    // fe_ptr is the next entry to move into the output register
    load     = (!out_valid || rready) && (fe_ptr != cm_ptr);
    rd_nx    = pop  ? rd_ptr + PTR_ONE : rd_ptr;
    fe_nx    = load ? fe_ptr + PTR_ONE : fe_ptr;
    wr_inc   = wr_ptr + PTR_ONE;
    // Filling the FIFO with nothing committed means this packet can never fit
    overflow = ((wr_inc ^ rd_ptr) == FULL_X) && (cm_ptr == rd_ptr);

    wr_nx    = wr_ptr;
    cm_nx    = cm_ptr;
    state_nx = state;
    wr_en    = 1'b0;
    drop_nx  = 1'b0;

    if (PKT_MODE == 0) begin
      if (wfire) begin
        wr_en = 1'b1;
        wr_nx = wr_inc;
      end
      cm_nx = wr_nx;
    end else begin
      case (state)
        S_IDLE, S_ACCEPT: begin
          if (wfire) begin
            if (wlast && wdrop) begin
              wr_nx    = cm_ptr;
              drop_nx  = 1'b1;
              state_nx = S_IDLE;
            end else if (wlast) begin
              wr_en    = 1'b1;
              wr_nx    = wr_inc;
              cm_nx    = wr_inc;
              state_nx = S_IDLE;
            end else if (overflow) begin
              wr_nx    = cm_ptr;
              drop_nx  = 1'b1;
              state_nx = S_DISCARD;
            end else begin
              wr_en    = 1'b1;
              wr_nx    = wr_inc;
              state_nx = S_ACCEPT;
            end
          end
        end
        S_DISCARD: begin
          if (wfire && wlast) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end

    full_nx   = ((wr_nx ^ rd_nx) == FULL_X);
    wlevel_nx = wr_nx - rd_nx;
    rlevel_nx = cm_nx - rd_nx;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {wlast, wdata};
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      rd_ptr    <= '0;
      fe_ptr    <= '0;
      wready_q  <= 1'b0;
      drop_q    <= 1'b0;
      af_q      <= 1'b0;
      ae_q      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      state    <= state_nx;
      wr_ptr   <= wr_nx;
      cm_ptr   <= cm_nx;
      rd_ptr   <= rd_nx;
      fe_ptr   <= fe_nx;
      wready_q <= (state_nx == S_DISCARD) || !full_nx;
      drop_q   <= drop_nx;
      af_q     <= LW'(wlevel_nx) >= AF_L;
      ae_q     <= LW'(rlevel_nx) <= AE_L;
      if (load) begin
        out_valid            <= 1'b1;
        {out_last, out_data} <= mem[fe_ptr[AW-1:0]];
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign wready        = wready_q;
  assign walmost_full  = af_q;
  assign wlevel        = LW'(wr_ptr - rd_ptr);
  assign rvalid        = out_valid;
  assign rdata         = out_data;
  assign rlast         = out_last;
  assign ralmost_empty = ae_q;
  assign rlevel        = LW'(cm_ptr - rd_ptr);
  assign drop_pulse    = drop_q;

endmodule

// File: doc/hs_fifo_sfifo_pkt.md
# hs_fifo_sfifo_pkt

Single-clock, parametrised packet FIFO that succeeds the dual-clock FIFO in the `hs_fifo` family. It keeps the same `w*`/`r*` valid-ready, last, drop and level port set. It adds a store-and-forward packet mode with packet drop and commit, auto-discard of oversize packets, and programmable almost-full and almost-empty thresholds. It sits between a packet producer and consumer in the same clock domain, typically ahead of a DMA or a framer.

## Interface
- `DATA_WIDTH`, 32: payload width in bits.
- `FIFO_DEPTH`, 16: entries; power of two, ≥ 4.
- `PKT_MODE`, 1: 0 = stream (cut-through), 1 = store-and-forward (reader sees committed packets only).
- `AF_THRESH`, `FIFO_DEPTH-2`: `walmost_full` when `wlevel` ≥ `AF_THRESH`.
- `AE_THRESH`, 2: `ralmost_empty` when `rlevel` ≤ `AE_THRESH`.
- `LW` = `$clog2(FIFO_DEPTH+1)`: level width (localparam).

Ports:
- `clk` in 1: single clock for all logic.
- `areset` in 1: reset. It is **asynchronous and active-high**.
- `wvalid` in 1: write beat valid.
- `wready` out 1: write beat accepted.
- `wdata` in `DATA_WIDTH`: write payload.
- `wlast` in 1: last beat of packet.
- `wdrop` in 1: discard current packet; qualifies the `wlast` beat only.
- `walmost_full` out 1: threshold flag.
- `wlevel` out `LW`: entries written, including uncommitted ones.
- `rvalid` out 1: read beat valid.
- `rready` in 1: consumer ready.
- `rdata` out `DATA_WIDTH`: read payload.
- `rlast` out 1: stored `wlast`.
- `ralmost_empty` out 1: threshold flag.
- `rlevel` out `LW`: entries visible to the reader.
- `drop_pulse` out 1: one-cycle pulse per dropped packet, whether explicit or overflow.

## Operation
- Storage is `FIFO_DEPTH` × (`DATA_WIDTH`+1) and holds data plus last.
- Pointers are `$clog2(FIFO_DEPTH)+1` bits wide. The extra MSB is the wrap bit.
  - Full when the pointers are equal except the MSB.
  - Empty when the pointers are equal.
- Pointers kept:
  - `wr_ptr`: speculative write pointer.
  - `cm_ptr`: commit pointer.
  - `rd_ptr`: read pointer.
- In `PKT_MODE`=0, `cm_ptr` tracks `wr_ptr` every cycle.
- Write handshake: a beat is accepted when `wvalid && wready`. `wready` = !full, except in DISCARD.
- Write FSM (`PKT_MODE`=1):
  - **IDLE**: no packet open. First accepted beat without `wlast` → ACCEPT. An accepted `wlast` beat commits immediately and the FSM stays in IDLE.
  - **ACCEPT**: stores beats.
    - Accepted `wlast && !wdrop`: `cm_ptr` ← `wr_ptr`+1 → IDLE.
    - Accepted `wlast && wdrop`: the beat is not stored, `wr_ptr` ← `cm_ptr`, `drop_pulse` fires → IDLE.
    - Full with `cm_ptr` == `rd_ptr` (a single packet larger than the FIFO): `wr_ptr` ← `cm_ptr`, `drop_pulse` fires → DISCARD.
  - **DISCARD**: `wready` = 1 and beats are sunk. Accepted `wlast` → IDLE with no further pulse.
- In stream mode, `wdrop` is ignored and there is no DISCARD state.
- Read side is first-word fall-through with a registered output stage.
  - `rvalid` stays high while `rd_ptr` != `cm_ptr` or the output register is full.
  - `rdata`/`rlast` hold stable while `rvalid && !rready`.
- Level arithmetic is modulo 2·`FIFO_DEPTH` on the pointers and is never negative.
  - `wlevel` = `wr_ptr`−`rd_ptr`, including the output register entry.
  - `rlevel` = `cm_ptr`−`rd_ptr`, including the output register entry.
- Both flags are registered from the next-state levels, so they are exact in the same cycle as the levels.

## Timing
- Reset values while `areset`=1: `wready`=0, all other outputs 0, FSM = IDLE, all pointers 0.
  - `wready` rises on the first `clk` edge after `areset` falls.
- Reset mid-packet: the uncommitted and committed data are lost. No `drop_pulse` is emitted.
- Stream latency: write accepted at edge N → `rvalid`=1 after edge N+1.
- Packet latency: `wlast` accepted at edge N → first beat of that packet valid after edge N+1.
- Full: `wready` is registered and falls in the cycle after the filling write.
  - A read at full frees a slot. `wready` rises one cycle later. There is no combinational `rready`→`wready` path.
- Simultaneous events:
  - Write and read on the same edge: levels are unchanged.
  - Commit and read on the same edge: `rlevel` += beats committed − 1.
- Drop rollback and a same-cycle read: both apply, and `wlevel` reflects both.
- Throughput is 1 beat/cycle in both directions when not full or empty.

## Test plan
- **Stream fill/drain**: `PKT_MODE`=0, `FIFO_DEPTH`=16. Write 16 beats 0..15 with `rready`=0.
  - `wready`=0 after the 16th, `wlevel`=16, `walmost_full`=1 from level 14.
  - Drain: data 0..15 in order, `rlevel` reaches 0, `ralmost_empty`=1 at ≤2.
- **Packet commit visibility**: `PKT_MODE`=1. Write a 5-beat packet A..E.
  - `rvalid` stays 0 through beat E.
  - After edge N+1, A..E read out with `rlast` only on E.
- **Explicit drop**: write packet P1 (3 beats, committed), then P2 of 4 beats with `wdrop`=1 on the last beat.
  - `drop_pulse` fires for 1 cycle, `wlevel` returns to 3.
  - The reader sees only P1.
- **Oversize packet**: write a 20-beat packet into the empty 16-entry FIFO.
  - `drop_pulse` fires once at full, `wready` stays 1 through beat 20.
  - `wlevel`=0 after; the next 2-beat packet is read correctly.
- **Wrap and simultaneous read/write**: read and write 1 beat/cycle for 100 beats, wrapping the pointers more than 6 times.
  - Data is in order, levels are constant.
  - Random `rready` backpressure: `rdata` is stable while stalled.
- **Reset mid-operation**: assert `areset` with 5 committed and 2 uncommitted entries.
  - All outputs are 0 immediately (asynchronous reset).
  - After release, the FIFO is empty, `wready`=1 one edge later, and no `drop_pulse`.
